// File: rtl/display_scan_mux.sv
`timescale 1ns/1ps
// display_scan_mux
//   Time-multiplexes a packed hex value across DIGITS common-anode digits,
//   feeding one nibble per cycle to the registered 7-segment decoder and
//   driving the active-low anodes aligned to that decoder's one-cycle latency.
//   A one-cycle dead time is inserted on every digit change to suppress
//   ghosting. VALUE is latched once per frame so the display never tears.
//
// Parameters
//   DIGITS    number of scanned digits (1..8)
//   PRESCALE  CLK cycles per digit slot (>= 3)
//
// Ports
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   VALUE  in   packed hex value, nibble i shown on digit i (digit 0 rightmost)
//   EN     in   display enable, low blanks all anodes
//   D      out  nibble to decoder_7_seg
//   AN     out  active-low anode enables, one-hot-low when lit
//   FRAME  out  one-cycle pulse when the shadow value is reloaded
//
// Optional build macro
//   DISPLAY_LZB_EN  leading-zero blanking: digit i>0 is dark when shadow
//                   nibbles i..DIGITS-1 are all zero. Undefined by default.
module display_scan_mux #(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned PRESCALE = 100000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic                  EN,
    output logic [3:0]            D,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    idx_d1;
    logic [4*DIGITS-1:0] shadow;
    logic                tick_d1;
    logic                tick_c;
    logic                last_c;
    logic [3:0]          nib_c;
    logic                blank_sel_c;

    // Slot boundary: last cycle of the current digit slot
    assign tick_c = (cnt == CNT_MAX);
    assign last_c = (idx == IDX_MAX);

    // Nibble of the shadow value for the digit currently being scanned
    always_comb begin
        nib_c = 4'h0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                nib_c = shadow[4*i +: 4];
            end
        end
    end

`ifdef DISPLAY_LZB_EN
    logic [DIGITS-1:0] blank_c;

    // Digit i>0 is dark when it and every digit to its left hold zero
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        blank_c  = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero   = all_zero && (shadow[4*i +: 4] == 4'h0);
            blank_c[i] = all_zero && (i > 0);
        end
    end

    // Looked up with the delayed index so the blank aligns with the anode
    assign blank_sel_c = blank_c[idx_d1];
`else
    assign blank_sel_c = 1'b0;
`endif

    // Prescaler, digit index and once-per-frame shadow reload
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            idx    <= '0;
            shadow <= '0;
            FRAME  <= 1'b0;
        end else begin
            cnt   <= tick_c ? '0 : cnt + CNT_W'(1);
            FRAME <= tick_c && last_c;
            if (tick_c) begin
                idx <= last_c ? '0 : idx + IDX_W'(1);
            end
            if (tick_c && last_c) begin
                shadow <= VALUE;
            end
        end
    end

    // Decoder feed and one-cycle pipeline matching the decoder latency
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            D       <= 4'h0;
            idx_d1  <= '0;
            tick_d1 <= 1'b1;
        end else begin
            D       <= nib_c;
            idx_d1  <= idx;
            tick_d1 <= tick_c;
        end
    end

    // Anodes: dark while disabled, during the dead cycle, or when blanked
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AN <= '1;
        end else if (!EN || tick_d1 || blank_sel_c) begin
            AN <= '1;
        end else begin
            AN <= ~(DIGITS'(1) << idx_d1);
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
`timescale 1ns/1ps
module tb_display_scan_mux;

    localparam int unsigned DIGITS   = 8;
    localparam int unsigned PRESCALE = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] VALUE = 32'h0;
    logic        EN = 1'b1;
    logic [3:0]  D;
    logic [7:0]  AN;
    logic        FRAME;

    int errors = 0;
    int checks = 0;
    int n = 0;                     // rising edges since reset release
    logic [31:0] shadow_m = 32'h0; // expected shadow after edge n
    logic [31:0] sh_prev  = 32'h0; // expected shadow before edge n
    logic        en_prev  = 1'b1;  // EN as seen by edge n
    logic [31:0] val_prev = 32'h0;

    display_scan_mux #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .CLK(CLK), .RST(RST), .VALUE(VALUE), .EN(EN),
        .D(D), .AN(AN), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    // Expected AN after edge e: slot of 4 edges, edge 4k+1 is the dead cycle
    function automatic logic [7:0] exp_an(input int e, input logic en, input logic [31:0] sh);
        int dg;
        logic lzb_on;
        logic [7:0] one;
`ifdef DISPLAY_LZB_EN
        lzb_on = 1'b1;
`else
        lzb_on = 1'b0;
`endif
        if (e < 2 || (e % 4) == 1 || !en) return 8'hFF;
        dg = ((e - 1) / 4) % 8;
        if (lzb_on && dg > 0 && (sh >> (4 * dg)) == 32'h0) return 8'hFF;
        one = 8'h01 << dg;
        return ~one;
    endfunction

    // Expected D after edge e: nibble of the digit whose slot edge e-1 was in
    function automatic logic [3:0] exp_d(input int e, input logic [31:0] sh);
        int dg;
        dg = ((e - 1) / 4) % 8;
        return 4'(sh >> (4 * dg));
    endfunction

    task automatic step();
        sh_prev  = shadow_m;
        en_prev  = EN;
        val_prev = VALUE;
        @(posedge CLK);
        #1;
        n++;
        if ((n % 32) == 0) shadow_m = val_prev;
    endtask

    task automatic test_reset();
        logic [7:0] an_tab [5];
        an_tab = '{8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFF};
        RST = 1'b1; EN = 1'b1; VALUE = 32'h76543210;
        #12;
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an got=%h exp=ff", AN); end
        checks++; if (D !== 4'h0) begin errors++; $display("FAIL reset_d got=%h exp=0", D); end
        checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame got=%b exp=0", FRAME); end
        @(negedge CLK);
        RST = 1'b0; n = 0; shadow_m = 32'h0; sh_prev = 32'h0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (AN !== an_tab[i]) begin errors++; $display("FAIL reset_release_an edge=%0d got=%h exp=%h", n, AN, an_tab[i]); end
            checks++;
            if (D !== 4'h0) begin errors++; $display("FAIL reset_release_d edge=%0d got=%h exp=0", n, D); end
        end
    endtask

    task automatic test_scan();
        int frames;
        frames = 0;
        while (n < 96) begin
            step();
            checks++;
            if (AN !== exp_an(n, en_prev, sh_prev)) begin errors++; $display("FAIL scan_an edge=%0d got=%h exp=%h", n, AN, exp_an(n, en_prev, sh_prev)); end
            checks++;
            if (D !== exp_d(n, sh_prev)) begin errors++; $display("FAIL scan_d edge=%0d got=%h exp=%h", n, D, exp_d(n, sh_prev)); end
            checks++;
            if (FRAME !== ((n % 32) == 0)) begin errors++; $display("FAIL scan_frame edge=%0d got=%b", n, FRAME); end
            if (FRAME === 1'b1) frames++;
        end
        checks++;
        if (frames != 3) begin errors++; $display("FAIL scan_frame_count got=%0d exp=3", frames); end
    endtask

    task automatic test_alignment();
        logic [3:0] prev_d;
        logic [7:0] exp_on;
        logic [7:0] one;
        logic pending;
        int trans;
        prev_d = D; pending = 1'b0; trans = 0; exp_on = 8'hFF;
        for (int i = 0; i < 32; i++) begin
            step();
            if (pending) begin
                checks++;
                if (AN !== exp_on) begin errors++; $display("FAIL align_lit edge=%0d got=%h exp=%h", n, AN, exp_on); end
                pending = 1'b0;
            end
            if (D !== prev_d) begin
                trans++;
                checks++;
                if (AN !== 8'hFF) begin errors++; $display("FAIL align_dead edge=%0d got=%h exp=ff", n, AN); end
                one = 8'h01 << D;
                exp_on = ~one;
                pending = 1'b1;
            end
            prev_d = D;
        end
        checks++;
        if (trans != 8) begin errors++; $display("FAIL align_transitions got=%0d exp=8", trans); end
    endtask

    task automatic test_tear();
        int guard;
        VALUE = 32'h11111111;
        guard = 0;
        do begin step(); guard++; end while (FRAME !== 1'b1 && guard < 40);
        checks++;
        if (FRAME !== 1'b1) begin errors++; $display("FAIL tear_first_frame timeout edge=%0d", n); end
        for (int i = 0; i < 9; i++) begin
            step();
            checks++;
            if (D !== 4'h1) begin errors++; $display("FAIL tear_pre edge=%0d got=%h exp=1", n, D); end
        end
        VALUE = 32'h22222222;
        guard = 0;
        do begin
            step(); guard++;
            checks++;
            if (D !== 4'h1) begin errors++; $display("FAIL tear_hold edge=%0d got=%h exp=1", n, D); end
        end while (FRAME !== 1'b1 && guard < 40);
        checks++;
        if (n != 192) begin errors++; $display("FAIL tear_frame_edge got=%0d exp=192", n); end
        step();
        checks++;
        if (D !== 4'h2) begin errors++; $display("FAIL tear_after got=%h exp=2", D); end
    endtask

    task automatic test_enable();
        step();
        EN = 1'b0;
        step();
        checks++;
        if (AN !== 8'hFF) begin errors++; $display("FAIL enable_fall got=%h exp=ff", AN); end
        for (int i = 0; i < 20; i++) begin
            if (i == 9) EN = 1'b1;
            step();
            checks++;
            if (AN !== exp_an(n, en_prev, sh_prev)) begin errors++; $display("FAIL enable_an edge=%0d got=%h exp=%h", n, AN, exp_an(n, en_prev, sh_prev)); end
            checks++;
            if (D !== exp_d(n, sh_prev)) begin errors++; $display("FAIL enable_phase edge=%0d got=%h exp=%h", n, D, exp_d(n, sh_prev)); end
        end
    endtask

    task automatic test_lzb();
        int guard;
        logic [7:0] seen;
        logic [7:0] exp_a05;
        logic [7:0] exp_zero;
`ifdef DISPLAY_LZB_EN
        exp_a05 = 8'h07; exp_zero = 8'h01;
`else
        exp_a05 = 8'hFF; exp_zero = 8'hFF;
`endif
        VALUE = 32'h00000A05;
        guard = 0;
        do begin step(); guard++; end while (FRAME !== 1'b1 && guard < 40);
        checks++;
        if (FRAME !== 1'b1) begin errors++; $display("FAIL lzb_frame1 timeout edge=%0d", n); end
        seen = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            seen |= ~AN;
            checks++;
            if (AN !== exp_an(n, en_prev, sh_prev)) begin errors++; $display("FAIL lzb_a05_an edge=%0d got=%h exp=%h", n, AN, exp_an(n, en_prev, sh_prev)); end
        end
        checks++;
        if (seen !== exp_a05) begin errors++; $display("FAIL lzb_a05_digits got=%h exp=%h", seen, exp_a05); end
        VALUE = 32'h0;
        guard = 0;
        do begin step(); guard++; end while (FRAME !== 1'b1 && guard < 40);
        checks++;
        if (FRAME !== 1'b1) begin errors++; $display("FAIL lzb_frame2 timeout edge=%0d", n); end
        seen = 8'h00;
        for (int i = 0; i < 32; i++) begin
            step();
            seen |= ~AN;
        end
        checks++;
        if (seen !== exp_zero) begin errors++; $display("FAIL lzb_zero_digits got=%h exp=%h", seen, exp_zero); end
    endtask

    task automatic test_reset_mid();
        VALUE = 32'h76543210;
        for (int i = 0; i < 6; i++) step();
        #3;
        RST = 1'b1;
        #1;
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL midrst_an got=%h exp=ff", AN); end
        checks++; if (D !== 4'h0) begin errors++; $display("FAIL midrst_d got=%h exp=0", D); end
        checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL midrst_frame got=%b exp=0", FRAME); end
        @(posedge CLK);
        #1;
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL midrst_hold_an got=%h exp=ff", AN); end
        VALUE = 32'h89ABCDEF;
        @(negedge CLK);
        RST = 1'b0; n = 0; shadow_m = 32'h0; sh_prev = 32'h0;
        for (int i = 0; i < 33; i++) begin
            step();
            checks++;
            if (D !== exp_d(n, sh_prev)) begin errors++; $display("FAIL midrst_d edge=%0d got=%h exp=%h", n, D, exp_d(n, sh_prev)); end
            checks++;
            if (AN !== exp_an(n, en_prev, sh_prev)) begin errors++; $display("FAIL midrst_an edge=%0d got=%h exp=%h", n, AN, exp_an(n, en_prev, sh_prev)); end
            if (n == 2) begin
                checks++;
                if (AN !== 8'hFE) begin errors++; $display("FAIL midrst_first_lit got=%h exp=fe", AN); end
            end
        end
        checks++;
        if (D !== 4'hF) begin errors++; $display("FAIL midrst_first_reload got=%h exp=f", D); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_alignment();
        test_tear();
        test_enable();
        test_lzb();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
